// File: rtl/pipe_beat_packer_if.sv
// Purpose: beat-in / word-out bundle between the stallable pipeline and the packer.
// Latency: n/a (signal grouping only).
// Backpressure: in_allow throttles the narrow side; out_ready throttles the wide side.
// Ports (slave view): in_valid/in_data/flush/out_ready in; in_allow/out_valid/out_data/out_cnt/pending out.
interface pipe_beat_packer_if #(
    parameter int WIDTH = 4,
    parameter int BEATS = 4,
    parameter int CNTW  = $clog2(BEATS + 1)
);
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_allow;
    logic                   flush;
    logic                   out_valid;
    logic [WIDTH*BEATS-1:0] out_data;
    logic [CNTW-1:0]        out_cnt;
    logic                   out_ready;
    logic                   pending;

    // Environment side: upstream pipeline plus downstream word consumer.
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_allow, out_valid, out_data, out_cnt, pending
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_allow, out_valid, out_data, out_cnt, pending
    );
endinterface

// File: rtl/pipe_beat_packer.sv
// Purpose: packs BEATS narrow beats into one wide word; flush emits a partial word.
// Latency: word visible 1 cycle after its last beat handshake (or qualifying flush).
// Backpressure: in_allow drops only when the next beat would complete a word and the
//   output register is occupied and not being drained this cycle.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the beat input
//   handshake, flush request, packed word output handshake and the pending flag.
module pipe_beat_packer #(
    parameter int WIDTH = 4,
    parameter int BEATS = 4,
    parameter int CNTW  = $clog2(BEATS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_beat_packer_if.slave    bus
);
    localparam logic [CNTW-1:0] LAST = CNTW'(BEATS - 1);

    logic [WIDTH*BEATS-1:0] acc_data_q, acc_data_d;
    logic [CNTW-1:0]        acc_cnt_q,  acc_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH*BEATS-1:0] out_data_q,  out_data_d;
    logic [CNTW-1:0]        out_cnt_q,   out_cnt_d;

    logic                   slot_free;
    logic                   in_allow;
    logic                   accept;
    logic                   full_done;
    logic                   flush_done;
    logic                   emit;
    logic [WIDTH*BEATS-1:0] merged;

    always_comb begin
        slot_free  = !out_valid_q || bus.out_ready;
        in_allow   = (acc_cnt_q != LAST) || slot_free;
        accept     = bus.in_valid && in_allow;
        full_done  = accept && (acc_cnt_q == LAST);
        // A flush only counts when it actually moves something and the completing
        // beat has not already produced a full word this cycle.
        flush_done = bus.flush && slot_free && ((acc_cnt_q != '0) || accept) && !full_done;
        emit       = full_done || flush_done;

        // Accumulator with this cycle's beat merged in; slices above the fill level
        // are still zero because the accumulator is cleared on every emit.
        merged = acc_data_q;
        for (int b = 0; b < BEATS; b++) begin
            if (accept && (acc_cnt_q == CNTW'(b))) begin
                merged[b*WIDTH +: WIDTH] = bus.in_data;
            end
        end

        acc_data_d  = acc_data_q;
        acc_cnt_d   = acc_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;

        if (emit) begin
            acc_data_d  = '0;
            acc_cnt_d   = '0;
            out_valid_d = 1'b1;
            out_data_d  = merged;
            out_cnt_d   = acc_cnt_q + CNTW'(accept);
        end else begin
            if (accept) begin
                acc_data_d = merged;
                acc_cnt_d  = acc_cnt_q + 1'b1;
            end
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_data_q  <= '0;
            acc_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
        end else begin
            acc_data_q  <= acc_data_d;
            acc_cnt_q   <= acc_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign bus.in_allow  = in_allow;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.pending   = (acc_cnt_q != '0) || out_valid_q;
endmodule

// File: tb/tb_pipe_beat_packer.sv
// Purpose: directed self-checking bench for pipe_beat_packer (WIDTH=4, BEATS=4).
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpressure: out_ready toggled explicitly per directed step.
module tb_pipe_beat_packer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pipe_beat_packer_if #(.WIDTH(4), .BEATS(4)) bus ();

    pipe_beat_packer #(.WIDTH(4), .BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle: drive point is 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic fl);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = fl;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_out_cnt",   bus.out_cnt,   0);
        chk("rst_in_allow",  bus.in_allow,  1);
        chk("rst_pending",   bus.pending,   0);

        // 1: four beats, out_ready high
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            chk("t1_in_allow", bus.in_allow, 1);
            tick();
            if (i == 3) chk("t1_no_early_valid", bus.out_valid, 0);
        end
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_data",  bus.out_data,  32'h4321);
        chk("t1_out_cnt",   bus.out_cnt,   4);
        drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("t1_valid_drop", bus.out_valid, 0);
        chk("t1_pending",    bus.pending,   0);

        // 2: stalled output, beats 1..8
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            chk("t2_in_allow", bus.in_allow, 1);
            tick();
            if (i >= 4) begin
                chk("t2_hold_valid", bus.out_valid, 1);
                chk("t2_hold_data",  bus.out_data,  32'h4321);
            end
        end
        drive(1'b1, 4'h8, 1'b0);
        chk("t2_stall_allow", bus.in_allow, 0);
        tick();
        chk("t2_stall_allow2", bus.in_allow, 0);
        chk("t2_stall_data",   bus.out_data, 32'h4321);
        chk("t2_pending",      bus.pending,  1);
        bus.out_ready = 1'b1;
        #1;
        chk("t2_release_allow", bus.in_allow, 1);
        tick();
        chk("t2_next_valid", bus.out_valid, 1);
        chk("t2_next_data",  bus.out_data,  32'h8765);
        chk("t2_next_cnt",   bus.out_cnt,   4);
        drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("t2_drain", bus.out_valid, 0);

        // 3: A,B then flush alone
        drive(1'b1, 4'hA, 1'b0);
        tick();
        drive(1'b1, 4'hB, 1'b0);
        tick();
        chk("t3_no_early_valid", bus.out_valid, 0);
        drive(1'b0, 4'h0, 1'b1);
        tick();
        chk("t3_out_valid", bus.out_valid, 1);
        chk("t3_out_data",  bus.out_data,  32'h00BA);
        chk("t3_out_cnt",   bus.out_cnt,   2);
        drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("t3_pending", bus.pending,   0);
        chk("t3_drain",   bus.out_valid, 0);

        // 4: A,B then C together with flush
        drive(1'b1, 4'hA, 1'b0);
        tick();
        drive(1'b1, 4'hB, 1'b0);
        tick();
        drive(1'b1, 4'hC, 1'b1);
        tick();
        chk("t4_out_valid", bus.out_valid, 1);
        chk("t4_out_data",  bus.out_data,  32'h0CBA);
        chk("t4_out_cnt",   bus.out_cnt,   3);
        drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("t4_pending", bus.pending, 0);

        // 5: flush on empty accumulator is a no-op
        drive(1'b0, 4'h0, 1'b1);
        tick();
        chk("t5_empty_valid",   bus.out_valid, 0);
        chk("t5_empty_pending", bus.pending,   0);
        // flush while a full word is stalled: ignored until the slot frees
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            tick();
        end
        drive(1'b0, 4'h0, 1'b1);
        tick();
        tick();
        chk("t5_stall_valid", bus.out_valid, 1);
        chk("t5_stall_data",  bus.out_data,  32'h4321);
        chk("t5_stall_cnt",   bus.out_cnt,   4);
        bus.out_ready = 1'b1;
        tick();
        chk("t5_flush_valid", bus.out_valid, 1);
        chk("t5_flush_data",  bus.out_data,  32'h0005);
        chk("t5_flush_cnt",   bus.out_cnt,   1);
        drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("t5_drain",   bus.out_valid, 0);
        chk("t5_pending", bus.pending,   0);

        // 6: reset mid-word discards partial beats
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            tick();
        end
        drive(1'b0, 4'h0, 1'b0);
        rst = 1'b1;
        tick();
        chk("t6_rst_valid",   bus.out_valid, 0);
        chk("t6_rst_pending", bus.pending,   0);
        chk("t6_rst_allow",   bus.in_allow,  1);
        rst = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            tick();
            if (i < 8) chk("t6_no_stale_valid", bus.out_valid, 0);
        end
        chk("t6_out_valid", bus.out_valid, 1);
        chk("t6_out_data",  bus.out_data,  32'h8765);
        chk("t6_out_cnt",   bus.out_cnt,   4);
        drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("t6_drain", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
